// File: rtl/vector_checker.sv
// ---------------------------------------------------------------------------
// vector_checker
//
// Response checker that sits directly downstream of the vector reader stage.
// Each expected word from the reader goes into a delay line that is LATENCY
// cycles deep. This lines the word up with the DUT output word produced for
// the same vector, so the pair can be compared in one cycle.
//
// Per run, the block counts the comparisons and the failing comparisons. It
// keeps the index and data of the first failure. When the vector flagged as
// last has been compared, it reports done and pass/fail.
//
// Parameters
//   WIDTH    : width of the DUT output word and of the expected word
//   LATENCY  : cycles from a vector entering the reader stage to its DUT
//              output being valid (0..8)
//   CNT_BITS : width of the vector counter, error counter and index register
//
// Ports
//   i_clk            : clock, all state changes on the rising edge
//   i_reset          : asynchronous reset, active low
//   i_start          : one-cycle pulse that begins a check run (IDLE/DONE only)
//   i_valid          : i_expected / i_last carry a vector this cycle
//   i_last           : marks the final vector of the run (qualified by i_valid)
//   i_expected       : expected DUT output for the current vector
//   i_dut_out        : DUT output word
//   o_busy           : run in progress (RUN or DRAIN)
//   o_done           : run finished, results held
//   o_pass           : run finished with no failing comparison
//   o_mismatch       : one-cycle pulse after each failing comparison
//   o_vector_count   : comparisons performed (saturating)
//   o_error_count    : failing comparisons (saturating)
//   o_first_err_idx  : 0-based vector index of the first failure
//   o_first_err_got  : DUT word at the first failure
//   o_first_err_exp  : expected word at the first failure
// ---------------------------------------------------------------------------
module vector_checker #(
  parameter int WIDTH    = 8,
  parameter int LATENCY  = 1,
  parameter int CNT_BITS = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_valid,
  input  logic                i_last,
  input  logic [WIDTH-1:0]    i_expected,
  input  logic [WIDTH-1:0]    i_dut_out,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic                o_mismatch,
  output logic [CNT_BITS-1:0] o_vector_count,
  output logic [CNT_BITS-1:0] o_error_count,
  output logic [CNT_BITS-1:0] o_first_err_idx,
  output logic [WIDTH-1:0]    o_first_err_got,
  output logic [WIDTH-1:0]    o_first_err_exp
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

  state_t              r_state;
  state_t              w_next_state;

  logic                w_accept;
  logic                w_clear;
  logic                w_cmp_valid;
  logic                w_cmp_last;
  logic [WIDTH-1:0]    w_cmp_exp;
  logic                w_compare;
  logic                w_mismatch;

  logic                r_mismatch;
  logic [CNT_BITS-1:0] r_vec_cnt;
  logic [CNT_BITS-1:0] r_err_cnt;
  logic [CNT_BITS-1:0] r_first_idx;
  logic [WIDTH-1:0]    r_first_got;
  logic [WIDTH-1:0]    r_first_exp;

  // New vectors enter the delay line only while the run is accepting vectors.
  // In DRAIN, IDLE and DONE, incoming i_valid is dropped at this point.
  assign w_accept = (r_state == S_RUN) && i_valid;

  // A start pulse only starts a run from IDLE or DONE.
  assign w_clear  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // ------------------------------------------------------------------------
  // Alignment delay line
  // ------------------------------------------------------------------------
  // {valid, last, expected} moves one stage every cycle. Bubbles travel as
  // valid=0 entries, so a gap in i_valid reaches the compare point as a cycle
  // with no comparison. With zero latency, the comparison uses the reader
  // word in the same cycle.
  if (LATENCY == 0) begin : g_no_delay
    assign w_cmp_valid = w_accept;
    assign w_cmp_last  = w_accept & i_last;
    assign w_cmp_exp   = i_expected;
  end else begin : g_delay
    logic [LATENCY-1:0]            r_dl_valid;
    logic [LATENCY-1:0]            r_dl_last;
    logic [LATENCY-1:0][WIDTH-1:0] r_dl_exp;

    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
        r_dl_valid <= '0;
        r_dl_last  <= '0;
        r_dl_exp   <= '0;
      end else begin
        r_dl_valid[0] <= w_accept;
        r_dl_last[0]  <= w_accept & i_last;
        r_dl_exp[0]   <= i_expected;
        for (int k = 1; k < LATENCY; k++) begin
          r_dl_valid[k] <= r_dl_valid[k-1];
          r_dl_last[k]  <= r_dl_last[k-1];
          r_dl_exp[k]   <= r_dl_exp[k-1];
        end
      end
    end

    assign w_cmp_valid = r_dl_valid[LATENCY-1];
    assign w_cmp_last  = r_dl_last[LATENCY-1];
    assign w_cmp_exp   = r_dl_exp[LATENCY-1];
  end

  // Comparisons count only during a run. After a reset the delay line is
  // empty, so this gate is a safety net and not a functional path.
  assign w_compare = w_cmp_valid && ((r_state == S_RUN) || (r_state == S_DRAIN));

  // The mismatch flag defaults to 1 and is cleared only when the equality
  // test is definitely true. In simulation, an X/Z bit in i_dut_out makes the
  // equality unknown, so the flag stays set and the vector counts as a
  // failure. In hardware this is a plain inequality compare.
  always_comb begin
    w_mismatch = 1'b0;
    if (w_compare) begin
      w_mismatch = 1'b1;
      if (i_dut_out == w_cmp_exp) begin
        w_mismatch = 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ------------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------------
  // With zero latency, the last vector is compared in the cycle it arrives,
  // so the block goes straight to DONE. Otherwise it waits in DRAIN until
  // the delayed last vector reaches the compare point.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (w_accept && i_last) begin
          w_next_state = (LATENCY == 0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_cmp_valid && w_cmp_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (i_start) begin
          w_next_state = S_RUN;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // State-derived outputs
  // ------------------------------------------------------------------------
  // o_pass is only meaningful in DONE. A saturated error counter is never
  // zero, so it still reports a failure.
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    o_pass = 1'b0;
    case (r_state)
      S_RUN, S_DRAIN: o_busy = 1'b1;
      S_DONE: begin
        o_done = 1'b1;
        o_pass = (r_err_cnt == '0);
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------------
  // Counters and first-failure capture
  // ------------------------------------------------------------------------
  // Both counters stop at all-ones and do not wrap. The first-failure
  // registers load only while the error count is still zero. The captured
  // index is the vector count before this comparison's increment.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_mismatch  <= 1'b0;
      r_vec_cnt   <= '0;
      r_err_cnt   <= '0;
      r_first_idx <= '0;
      r_first_got <= '0;
      r_first_exp <= '0;
    end else begin
      r_mismatch <= 1'b0;
      if (w_clear) begin
        r_vec_cnt   <= '0;
        r_err_cnt   <= '0;
        r_first_idx <= '0;
        r_first_got <= '0;
        r_first_exp <= '0;
      end else if (w_compare) begin
        if (r_vec_cnt != CNT_MAX) begin
          r_vec_cnt <= r_vec_cnt + 1'b1;
        end
        if (w_mismatch) begin
          r_mismatch <= 1'b1;
          if (r_err_cnt != CNT_MAX) begin
            r_err_cnt <= r_err_cnt + 1'b1;
          end
          if (r_err_cnt == '0) begin
            r_first_idx <= r_vec_cnt;
            r_first_got <= i_dut_out;
            r_first_exp <= w_cmp_exp;
          end
        end
      end
    end
  end

  assign o_mismatch      = r_mismatch;
  assign o_vector_count  = r_vec_cnt;
  assign o_error_count   = r_err_cnt;
  assign o_first_err_idx = r_first_idx;
  assign o_first_err_got = r_first_got;
  assign o_first_err_exp = r_first_exp;

endmodule

// File: tb/tb_vector_checker.sv
// ---------------------------------------------------------------------------
// tb_vector_checker
//
// Four checkers run side by side on shared reader-side stimulus:
//   inst 0 : LATENCY=0, CNT_BITS=16
//   inst 1 : LATENCY=1, CNT_BITS=16
//   inst 2 : LATENCY=3, CNT_BITS=16
//   inst 3 : LATENCY=1, CNT_BITS=2
//
// Each instance gets its own DUT-output stream, which is the per-vector
// response delayed by that instance's latency. Expected results come from
// vector-level rules: count the accepted vectors up to the last one, count
// the responses that differ, and note the first difference.
// ---------------------------------------------------------------------------
module tb_vector_checker;

  logic            clk;
  logic            rstN;
  logic            iStart;
  logic            iValid;
  logic            iLast;
  logic [7:0]      iExpected;
  logic [3:0][7:0] dutV;

  logic [3:0]       busyV, doneV, passV, misV;
  logic [3:0][15:0] vecV, errV, idxV;
  logic [3:0][7:0]  gotV, expV;

  int total;
  int bad;

  // Per-cycle stimulus tables, indexed by cycle relative to the run start.
  logic       stStart [64];
  logic       stValid [64];
  logic       stLast  [64];
  logic [7:0] stExp   [64];
  logic [7:0] stResp  [64];

  // Observations gathered while a run is driven.
  int misCnt  [4];
  int doneAt  [4];
  int busyCnt [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int L  = (g == 0) ? 0 : ((g == 2) ? 3 : 1);
    localparam int CB = (g == 3) ? 2 : 16;
    logic [CB-1:0] wVec, wErr, wIdx;

    vector_checker #(.WIDTH(8), .LATENCY(L), .CNT_BITS(CB)) u_dut (
      .i_clk           (clk),
      .i_reset         (rstN),
      .i_start         (iStart),
      .i_valid         (iValid),
      .i_last          (iLast),
      .i_expected      (iExpected),
      .i_dut_out       (dutV[g]),
      .o_busy          (busyV[g]),
      .o_done          (doneV[g]),
      .o_pass          (passV[g]),
      .o_mismatch      (misV[g]),
      .o_vector_count  (wVec),
      .o_error_count   (wErr),
      .o_first_err_idx (wIdx),
      .o_first_err_got (gotV[g]),
      .o_first_err_exp (expV[g])
    );

    assign vecV[g] = 16'(wVec);
    assign errV[g] = 16'(wErr);
    assign idxV[g] = 16'(wIdx);
  end

  function automatic int latOf(input int g);
    return (g == 0) ? 0 : ((g == 2) ? 3 : 1);
  endfunction

  // Counter value as seen through an instance's saturating counter width.
  function automatic int satTo(input int v, input int g);
    int mx;
    mx = (g == 3) ? 3 : 65535;
    return (v > mx) ? mx : v;
  endfunction

  // Fill the tables with junk. Each scenario then overwrites its run window.
  task automatic clear_stim();
    for (int c = 0; c < 64; c++) begin
      stStart[c] = 1'b0;
      stValid[c] = 1'($urandom_range(0, 1));
      stLast[c]  = 1'($urandom_range(0, 1));
      stExp[c]   = 8'($urandom);
      stResp[c]  = 8'($urandom);
    end
  endtask

  // The DUT answers each reader cycle after its latency. Before that it
  // outputs noise.
  task automatic drive_cycle(input int c);
    iStart    = stStart[c];
    iValid    = stValid[c];
    iLast     = stLast[c];
    iExpected = stExp[c];
    for (int g = 0; g < 4; g++) begin
      dutV[g] = (c >= latOf(g)) ? stResp[c - latOf(g)] : 8'($urandom);
    end
  endtask

  task automatic drive_run(input int nTot);
    for (int g = 0; g < 4; g++) begin
      misCnt[g]  = 0;
      doneAt[g]  = -1;
      busyCnt[g] = 0;
    end
    for (int c = 0; c < nTot; c++) begin
      @(posedge clk);
      #1;
      drive_cycle(c);
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (misV[g] === 1'b1) misCnt[g]++;
        if (busyV[g] === 1'b1) busyCnt[g]++;
        if (doneV[g] === 1'b1 && c >= 1 && doneAt[g] < 0) doneAt[g] = c;
      end
    end
  endtask

  // Vector-level reference. The run starts at the first start pulse. Every
  // valid cycle after it is one vector, until the vector flagged last.
  task automatic model_run(output int eVec, output int eErr, output int eIdx,
                           output logic [7:0] eGot, output logic [7:0] eExp,
                           output int eLast);
    int s;
    int k;
    s = -1;
    for (int c = 63; c >= 0; c--) if (stStart[c]) s = c;
    k = 0; eErr = 0; eIdx = 0; eGot = 8'h00; eExp = 8'h00; eLast = -1;
    for (int c = s + 1; c < 64; c++) begin
      if (eLast < 0 && stValid[c]) begin
        if (stResp[c] != stExp[c]) begin
          if (eErr == 0) begin
            eIdx = k; eGot = stResp[c]; eExp = stExp[c];
          end
          eErr++;
        end
        k++;
        if (stLast[c]) eLast = c;
      end
    end
    eVec = k;
  endtask

  task automatic test_reset();
    rstN = 1'b0; iStart = 1'b0; iValid = 1'b0; iLast = 1'b0; iExpected = 8'h00; dutV = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      total++; if (busyV[g] !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy inst=%0d got=%b want=0", g, busyV[g]); end
      total++; if (doneV[g] !== 1'b0) begin bad++; $display("[TB] FAIL reset_done inst=%0d got=%b want=0", g, doneV[g]); end
      total++; if (passV[g] !== 1'b0) begin bad++; $display("[TB] FAIL reset_pass inst=%0d got=%b want=0", g, passV[g]); end
      total++; if (misV[g] !== 1'b0) begin bad++; $display("[TB] FAIL reset_mis inst=%0d got=%b want=0", g, misV[g]); end
      total++; if (vecV[g] !== 16'd0 || errV[g] !== 16'd0 || idxV[g] !== 16'd0)
        begin bad++; $display("[TB] FAIL reset_cnt inst=%0d got=%0d/%0d/%0d want=0/0/0", g, vecV[g], errV[g], idxV[g]); end
      total++; if (gotV[g] !== 8'h00 || expV[g] !== 8'h00)
        begin bad++; $display("[TB] FAIL reset_first inst=%0d got=%h/%h want=00/00", g, gotV[g], expV[g]); end
    end
    rstN = 1'b1;
  endtask

  task automatic test_clean_run();
    clear_stim();
    stStart[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      stValid[k+1] = 1'b1; stLast[k+1] = (k == 4);
      stExp[k+1] = 8'(k + 1); stResp[k+1] = 8'(k + 1);
    end
    drive_run(13);
    for (int g = 0; g < 4; g++) begin
      total++; if (vecV[g] !== 16'(satTo(5, g))) begin bad++; $display("[TB] FAIL clean_vec inst=%0d got=%0d want=%0d", g, vecV[g], satTo(5, g)); end
      total++; if (errV[g] !== 16'd0) begin bad++; $display("[TB] FAIL clean_err inst=%0d got=%0d want=0", g, errV[g]); end
      total++; if (passV[g] !== 1'b1) begin bad++; $display("[TB] FAIL clean_pass inst=%0d got=%b want=1", g, passV[g]); end
      total++; if (doneAt[g] != 5 + latOf(g) + 1) begin bad++; $display("[TB] FAIL clean_done_time inst=%0d got=%0d want=%0d", g, doneAt[g], 6 + latOf(g)); end
      total++; if (busyCnt[g] != 5 + latOf(g)) begin bad++; $display("[TB] FAIL clean_busy inst=%0d got=%0d want=%0d", g, busyCnt[g], 5 + latOf(g)); end
    end
  endtask

  task automatic test_single_error();
    clear_stim();
    stStart[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      stValid[k+1] = 1'b1; stLast[k+1] = (k == 4);
      stExp[k+1] = 8'(k + 1); stResp[k+1] = 8'(k + 1);
    end
    stResp[3] = 8'hFF;
    drive_run(13);
    for (int g = 0; g < 4; g++) begin
      total++; if (misCnt[g] != 1) begin bad++; $display("[TB] FAIL err1_pulses inst=%0d got=%0d want=1", g, misCnt[g]); end
      total++; if (errV[g] !== 16'd1) begin bad++; $display("[TB] FAIL err1_count inst=%0d got=%0d want=1", g, errV[g]); end
      total++; if (idxV[g] !== 16'd2) begin bad++; $display("[TB] FAIL err1_idx inst=%0d got=%0d want=2", g, idxV[g]); end
      total++; if (gotV[g] !== 8'hFF) begin bad++; $display("[TB] FAIL err1_got inst=%0d got=%h want=ff", g, gotV[g]); end
      total++; if (expV[g] !== 8'h03) begin bad++; $display("[TB] FAIL err1_exp inst=%0d got=%h want=03", g, expV[g]); end
      total++; if (passV[g] !== 1'b0 || doneV[g] !== 1'b1)
        begin bad++; $display("[TB] FAIL err1_pass inst=%0d got=%b/%b want=0/1", g, passV[g], doneV[g]); end
    end
  endtask

  task automatic test_gap();
    clear_stim();
    stStart[0] = 1'b1;
    stValid[1] = 1'b1; stValid[2] = 1'b0; stValid[3] = 1'b1; stValid[4] = 1'b1;
    stLast[1] = 1'b0; stLast[2] = 1'b1; stLast[3] = 1'b0; stLast[4] = 1'b1;
    for (int c = 1; c <= 4; c++) stResp[c] = stExp[c];
    stResp[2] = ~stExp[2];
    drive_run(12);
    for (int g = 0; g < 4; g++) begin
      total++; if (vecV[g] !== 16'(satTo(3, g))) begin bad++; $display("[TB] FAIL gap_vec inst=%0d got=%0d want=%0d", g, vecV[g], satTo(3, g)); end
      total++; if (errV[g] !== 16'd0 || passV[g] !== 1'b1)
        begin bad++; $display("[TB] FAIL gap_err inst=%0d got=%0d/%b want=0/1", g, errV[g], passV[g]); end
      total++; if (doneAt[g] != 4 + latOf(g) + 1) begin bad++; $display("[TB] FAIL gap_done_time inst=%0d got=%0d want=%0d", g, doneAt[g], 5 + latOf(g)); end
    end
  endtask

  task automatic test_single_vector();
    clear_stim();
    stStart[0] = 1'b1;
    stValid[1] = 1'b1; stLast[1] = 1'b1; stResp[1] = stExp[1];
    drive_run(9);
    for (int g = 0; g < 4; g++) begin
      total++; if (vecV[g] !== 16'd1) begin bad++; $display("[TB] FAIL one_vec inst=%0d got=%0d want=1", g, vecV[g]); end
      total++; if (doneAt[g] != 2 + latOf(g)) begin bad++; $display("[TB] FAIL one_done_time inst=%0d got=%0d want=%0d", g, doneAt[g], 2 + latOf(g)); end
    end
  endtask

  task automatic test_restart();
    clear_stim();
    stStart[0] = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      stValid[c] = 1'b1; stLast[c] = (c == 2); stResp[c] = stExp[c];
    end
    drive_run(10);
    for (int g = 0; g < 4; g++) begin
      total++; if (vecV[g] !== 16'd2) begin bad++; $display("[TB] FAIL restart_vec inst=%0d got=%0d want=2", g, vecV[g]); end
      total++; if (errV[g] !== 16'd0 || passV[g] !== 1'b1)
        begin bad++; $display("[TB] FAIL restart_err inst=%0d got=%0d/%b want=0/1", g, errV[g], passV[g]); end
      total++; if (idxV[g] !== 16'd0 || gotV[g] !== 8'h00 || expV[g] !== 8'h00)
        begin bad++; $display("[TB] FAIL restart_first inst=%0d got=%0d/%h/%h want=0/00/00", g, idxV[g], gotV[g], expV[g]); end
    end
  endtask

  // Without a start pulse, DONE holds its results and valid vectors are dropped.
  task automatic test_hold_in_done();
    clear_stim();
    for (int c = 0; c < 10; c++) begin
      stValid[c] = 1'b1; stLast[c] = 1'b1; stResp[c] = ~stExp[c];
    end
    drive_run(10);
    for (int g = 0; g < 4; g++) begin
      total++; if (vecV[g] !== 16'd2 || errV[g] !== 16'd0)
        begin bad++; $display("[TB] FAIL hold_cnt inst=%0d got=%0d/%0d want=2/0", g, vecV[g], errV[g]); end
      total++; if (misCnt[g] != 0 || busyCnt[g] != 0)
        begin bad++; $display("[TB] FAIL hold_activity inst=%0d got=%0d/%0d want=0/0", g, misCnt[g], busyCnt[g]); end
      total++; if (doneV[g] !== 1'b1 || passV[g] !== 1'b1)
        begin bad++; $display("[TB] FAIL hold_done inst=%0d got=%b/%b want=1/1", g, doneV[g], passV[g]); end
    end
  endtask

  task automatic test_saturation();
    clear_stim();
    stStart[0] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      stValid[c] = 1'b1; stLast[c] = (c == 6); stResp[c] = ~stExp[c];
    end
    drive_run(14);
    for (int g = 0; g < 4; g++) begin
      total++; if (vecV[g] !== 16'(satTo(6, g))) begin bad++; $display("[TB] FAIL sat_vec inst=%0d got=%0d want=%0d", g, vecV[g], satTo(6, g)); end
      total++; if (errV[g] !== 16'(satTo(6, g))) begin bad++; $display("[TB] FAIL sat_err inst=%0d got=%0d want=%0d", g, errV[g], satTo(6, g)); end
      total++; if (idxV[g] !== 16'd0) begin bad++; $display("[TB] FAIL sat_idx inst=%0d got=%0d want=0", g, idxV[g]); end
      total++; if (gotV[g] !== ~stExp[1] || expV[g] !== stExp[1])
        begin bad++; $display("[TB] FAIL sat_first inst=%0d got=%h/%h want=%h/%h", g, gotV[g], expV[g], ~stExp[1], stExp[1]); end
      total++; if (passV[g] !== 1'b0 || misCnt[g] != 6)
        begin bad++; $display("[TB] FAIL sat_pass inst=%0d got=%b/%0d want=0/6", g, passV[g], misCnt[g]); end
    end
  endtask

  task automatic test_random(input int runId);
    int nVec, c, placed, eVec, eErr, eIdx, eLast;
    logic [7:0] eGot, eExp;
    clear_stim();
    stStart[0] = 1'b1;
    nVec = int'($urandom_range(1, 12));
    c = 1;
    placed = 0;
    while (placed < nVec) begin
      if (c >= 40 || $urandom_range(0, 99) < 70) begin
        stValid[c] = 1'b1;
        stLast[c]  = (placed == nVec - 1);
        stResp[c]  = ($urandom_range(0, 99) < 25) ? (stExp[c] ^ 8'($urandom_range(1, 255))) : stExp[c];
        placed++;
      end else begin
        stValid[c] = 1'b0;
      end
      c++;
    end
    for (int s = 2; s < c - 1; s++) stStart[s] = ($urandom_range(0, 9) == 0);
    model_run(eVec, eErr, eIdx, eGot, eExp, eLast);
    drive_run(eLast + 8);
    for (int g = 0; g < 4; g++) begin
      total++; if (vecV[g] !== 16'(satTo(eVec, g))) begin bad++; $display("[TB] FAIL rand%0d_vec inst=%0d got=%0d want=%0d", runId, g, vecV[g], satTo(eVec, g)); end
      total++; if (errV[g] !== 16'(satTo(eErr, g))) begin bad++; $display("[TB] FAIL rand%0d_err inst=%0d got=%0d want=%0d", runId, g, errV[g], satTo(eErr, g)); end
      total++; if (idxV[g] !== 16'(satTo(eIdx, g))) begin bad++; $display("[TB] FAIL rand%0d_idx inst=%0d got=%0d want=%0d", runId, g, idxV[g], satTo(eIdx, g)); end
      total++; if (gotV[g] !== eGot || expV[g] !== eExp)
        begin bad++; $display("[TB] FAIL rand%0d_first inst=%0d got=%h/%h want=%h/%h", runId, g, gotV[g], expV[g], eGot, eExp); end
      total++; if (passV[g] !== 1'(eErr == 0)) begin bad++; $display("[TB] FAIL rand%0d_pass inst=%0d got=%b want=%b", runId, g, passV[g], eErr == 0); end
      total++; if (misCnt[g] != eErr) begin bad++; $display("[TB] FAIL rand%0d_pulses inst=%0d got=%0d want=%0d", runId, g, misCnt[g], eErr); end
      total++; if (doneAt[g] != eLast + latOf(g) + 1) begin bad++; $display("[TB] FAIL rand%0d_done_time inst=%0d got=%0d want=%0d", runId, g, doneAt[g], eLast + latOf(g) + 1); end
      total++; if (busyCnt[g] != eLast + latOf(g)) begin bad++; $display("[TB] FAIL rand%0d_busy inst=%0d got=%0d want=%0d", runId, g, busyCnt[g], eLast + latOf(g)); end
    end
  endtask

  task automatic test_reset_midrun();
    int doneSeen [4];
    int busySeen [4];
    clear_stim();
    stStart[0] = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      stValid[c] = 1'b1; stLast[c] = (c == 4); stResp[c] = stExp[c];
    end
    for (int c = 0; c <= 6; c++) begin
      @(posedge clk);
      #1;
      drive_cycle(c);
    end
    #1;
    total++; if (busyV[2] !== 1'b1) begin bad++; $display("[TB] FAIL midrst_draining got=%b want=1", busyV[2]); end
    #1 rstN = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) begin
      total++; if (busyV[g] !== 1'b0 || doneV[g] !== 1'b0 || passV[g] !== 1'b0 || misV[g] !== 1'b0)
        begin bad++; $display("[TB] FAIL midrst_flags inst=%0d got=%b%b%b%b want=0000", g, busyV[g], doneV[g], passV[g], misV[g]); end
      total++; if (vecV[g] !== 16'd0 || errV[g] !== 16'd0 || idxV[g] !== 16'd0 || gotV[g] !== 8'h00 || expV[g] !== 8'h00)
        begin bad++; $display("[TB] FAIL midrst_regs inst=%0d got=%0d/%0d/%0d/%h/%h want=0", g, vecV[g], errV[g], idxV[g], gotV[g], expV[g]); end
      doneSeen[g] = 0;
      busySeen[g] = 0;
    end
    #1 rstN = 1'b1;
    for (int c = 7; c < 17; c++) begin
      @(posedge clk);
      #1;
      drive_cycle(c);
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (doneV[g] === 1'b1) doneSeen[g]++;
        if (busyV[g] === 1'b1) busySeen[g]++;
      end
    end
    for (int g = 0; g < 4; g++) begin
      total++; if (doneSeen[g] != 0 || busySeen[g] != 0)
        begin bad++; $display("[TB] FAIL midrst_idle inst=%0d got=%0d/%0d want=0/0", g, doneSeen[g], busySeen[g]); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_clean_run();
    test_single_error();
    test_gap();
    test_single_vector();
    test_restart();
    test_hold_in_done();
    test_saturation();
    for (int r = 0; r < 6; r++) test_random(r);
    test_reset_midrun();
    test_clean_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=running want=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
